// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring divide, with valid/ready handshakes on both sides.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             less
);

    localparam int unsigned SH = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SH-1:0]    r_cnt;
    logic [2:0]       r_mop;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_opnd;
    logic [W2-1:0]    r_acc;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_less;

    logic             w_load_alu;
    logic             w_start;
    logic             w_iter;
    logic             w_finish;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign less      = r_less;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and datapath control strobes
    always_comb begin
        w_next     = r_state;
        w_load_alu = 1'b0;
        w_start    = 1'b0;
        w_iter     = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (op[4]) begin
                        w_next  = S_CALC;
                        w_start = 1'b1;
                    end else begin
                        w_next     = S_DONE;
                        w_load_alu = 1'b1;
                    end
                end
            end
            S_CALC: begin
                w_iter = 1'b1;
                if (r_cnt == SH'(WIDTH - 1)) begin
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Single-cycle ALU evaluated on the live inputs at accept
    logic [SH-1:0]    w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_zero;
    logic             w_alu_less;

    assign w_shamt = datab[SH-1:0];
    assign w_lt_s  = $signed(dataa) < $signed(datab);
    assign w_lt_u  = dataa < datab;

    always_comb begin
        w_alu_res = '0;
        case (op[2:0])
            3'b000: w_alu_res = op[3] ? (dataa - datab) : (dataa + datab);
            3'b001: w_alu_res = dataa << w_shamt;
            3'b010: w_alu_res = WIDTH'(op[3] ? w_lt_u : w_lt_s);
            3'b011: w_alu_res = datab;
            3'b100: w_alu_res = dataa ^ datab;
            3'b101: w_alu_res = op[3] ? WIDTH'($signed(dataa) >>> w_shamt) : (dataa >> w_shamt);
            3'b110: w_alu_res = dataa | datab;
            3'b111: w_alu_res = dataa & datab;
            default: w_alu_res = '0;
        endcase
        w_alu_less = op[3] ? w_lt_u : w_lt_s;
        w_alu_zero = (op[2:0] == 3'b010) ? (dataa == datab) : (w_alu_res == '0);
    end

    // Operand magnitudes for signed DIV/REM (op[2]=1, op[0]=0)
    logic             w_sdiv;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_sdiv  = op[2] & ~op[0];
    assign w_a_neg = w_sdiv & dataa[WIDTH-1];
    assign w_b_neg = w_sdiv & datab[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-dataa) : dataa;
    assign w_b_mag = w_b_neg ? (-datab) : datab;

    // One shift-add or restoring-divide step on the shared accumulator
    logic [WIDTH:0]   w_mul_sum;
    logic [W2-1:0]    w_mul_next;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [W2-1:0]    w_div_next;
    logic [W2-1:0]    w_acc_step;

    assign w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_rem_sh   = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_ge};
    assign w_acc_step = r_mop[2] ? w_div_next : w_mul_next;

    // Final mul/div result with sign fix-up and divide-by-zero override
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_md_res;

    assign w_q = w_acc_step[WIDTH-1:0];
    assign w_r = w_acc_step[W2-1:WIDTH];

    always_comb begin
        w_md_res = '0;
        case (r_mop)
            3'b000: w_md_res = w_q;
            3'b001: w_md_res = w_r;
            3'b100: w_md_res = r_div0 ? '1 : (r_neg_q ? (-w_q) : w_q);
            3'b101: w_md_res = r_div0 ? '1 : w_q;
            3'b110: w_md_res = r_div0 ? r_a : (r_neg_r ? (-w_r) : w_r);
            3'b111: w_md_res = r_div0 ? r_a : w_r;
            default: w_md_res = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mop    <= '0;
            r_a      <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_less   <= 1'b0;
        end else begin
            if (w_load_alu) begin
                r_result <= w_alu_res;
                r_zero   <= w_alu_zero;
                r_less   <= w_alu_less;
            end
            if (w_start) begin
                r_cnt   <= '0;
                r_mop   <= op[2:0];
                r_a     <= dataa;
                r_div0  <= (datab == '0);
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                if (op[2]) begin
                    r_opnd <= w_b_mag;
                    r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                end else begin
                    r_opnd <= dataa;
                    r_acc  <= {{WIDTH{1'b0}}, datab};
                end
            end
            if (w_iter) begin
                r_cnt <= r_cnt + SH'(1);
                r_acc <= w_acc_step;
            end
            if (w_finish) begin
                r_result <= w_md_res;
                r_zero   <= (w_md_res == '0);
                r_less   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 Derived constant: SH = log2(WIDTH), the shift-amount width.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: op  input  5  operation; op[4]=0 selects a single-cycle ALU op, op[4]=1 selects an iterative mul/div op.
REQ-008 Port: dataa  input  WIDTH  operand A.
REQ-009 Port: datab  input  WIDTH  operand B.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer takes the result.
REQ-012 Port: result  output  WIDTH  registered result.
REQ-013 Port: zero  output  1  registered zero flag.
REQ-014 Port: less  output  1  registered less flag.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE; in_ready=1 only in IDLE.
REQ-016 A request is accepted on a cycle where in_valid=1 and in_ready=1; op, dataa and datab are captured on that edge.
REQ-017 For op[4]=0 the FSM goes IDLE->DONE; out_valid=1 on the cycle after acceptance (latency 1).
REQ-018 For op[4]=1 the FSM goes IDLE->CALC, runs exactly WIDTH iterations, then goes CALC->DONE; out_valid=1 WIDTH+1 cycles after acceptance.
REQ-019 In DONE, result, zero and less SHALL hold stable until out_valid=1 and out_ready=1, then the FSM goes DONE->IDLE.
REQ-020 There is no accept in the same cycle as a DONE->IDLE transition; back-to-back throughput is at most one op per 2 cycles.
REQ-021 ALU op[3:0] encoding:
- 0000 A+B; 1000 A-B (both modulo 2^WIDTH).
- x001 A<<B[SH-1:0].
- 0010 signed A<B -> 1/0; 1010 unsigned A<B -> 1/0.
- x011 B.
- x100 A^B.
- 0101 logical A>>B[SH-1:0]; 1101 arithmetic A>>>B[SH-1:0].
- x110 A|B; x111 A&B.
REQ-022 For ALU ops, zero = (A==B) for 0010/1010, otherwise zero = (result==0); less = the op-3 comparison (signed for op[3]=0, unsigned for op[3]=1) for every ALU op.
REQ-023 Mul/div op[2:0] encoding:
- 000 MUL: low WIDTH bits of A*B.
- 001 MULHU: high WIDTH bits of unsigned A*B.
- 100 DIV: signed quotient, truncated toward zero.
- 101 DIVU: unsigned quotient.
- 110 REM: signed remainder, sign of dividend.
- 111 REMU: unsigned remainder.
- 010 and 011 are reserved and SHALL produce result 0 after WIDTH iterations.
REQ-024 Multiply is shift-add, one bit per iteration, with a 2*WIDTH accumulator.
REQ-025 Divide is restoring, one quotient bit per iteration, on operand magnitudes; signs are applied in the DONE transition.
REQ-026 Divide by zero SHALL give quotient all-ones and remainder = A, for both signed and unsigned.
REQ-027 Signed overflow (A = most-negative, B = -1) SHALL give DIV result = A and REM result = 0.
REQ-028 For mul/div ops, zero = (result==0) and less = 0.
REQ-029 Inputs SHALL be ignored while in CALC or DONE; in_valid may toggle freely there.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, less=0, iteration counter=0.
REQ-031 Reset mid-CALC or mid-DONE SHALL abort the operation without producing a result; the first accept after deassertion behaves as from power-up.

Verification
REQ-032 WIDTH=32, op=00000, A=0x7FFFFFFF, B=1, out_ready=1 -> one cycle later out_valid=1, result=0x80000000, zero=0, less=0.
REQ-033 op=00010 with A=B=5 -> result=0, zero=1, less=0; then op=01010 with A=1, B=0xFFFFFFFF -> result=1, less=1, zero=0.
REQ-034 op=10000, A=0xFFFF, B=0x10001 -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFF; MULHU on the same operands -> 0x0.
REQ-035 op=10100 with A=0x80000000, B=0xFFFFFFFF -> result=0x80000000; op=10110 on the same operands -> 0; op=10101 with B=0 -> 0xFFFFFFFF; op=10111 with A=7, B=0 -> 7.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid with in_valid=1 -> result is stable, in_ready=0 and no second accept occurs; out_ready=1 releases the result, and the next request is accepted one cycle later.
REQ-037 Assert rst_n=0 during cycle 10 of a DIV -> out_valid=0 and in_ready=1 immediately; a fresh DIVU of 100/7 gives result 14.
